// File: rtl/branch_predictor_bht.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry. Predicts combinationally from PC_IF, resolves the EX
// branch (mispredict / redirect) and trains the table on the clock edge.
module branch_predictor_bht #(
   parameter  int INDEX_W = 6,
   localparam int TAG_W   = 32 - INDEX_W - 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC_IF,
   output logic        Br_pred,
   output logic [31:0] PC_pred,
   input  logic        update_en,
   input  logic [31:0] PC_EX,
   input  logic        Br_pred_EX,
   input  logic        br_taken_EX,
   input  logic [31:0] br_target_EX,
   output logic        mispredict,
   output logic [31:0] PC_correct,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);

   localparam int DEPTH = 1 << INDEX_W;

   logic             valid_q  [DEPTH];
   logic             valid_d  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [TAG_W-1:0] tag_d    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [31:0]      target_d [DEPTH];
   logic [1:0]       cnt_q    [DEPTH];
   logic [1:0]       cnt_d    [DEPTH];

   logic [31:0] branch_cnt_q, branch_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   logic [INDEX_W-1:0] idx_if, idx_ex;
   logic [TAG_W-1:0]   tag_if, tag_ex;
   logic               hit_if, hit_ex;

   // Byte-offset bits never take part in indexing or tag compare.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

   assign idx_if = PC_IF[INDEX_W+1:2];
   assign tag_if = PC_IF[31:INDEX_W+2];
   assign idx_ex = PC_EX[INDEX_W+1:2];
   assign tag_ex = PC_EX[31:INDEX_W+2];

   // Prediction reads the registered table only, so a same-index write in
   // this cycle is not visible until the next one.
   always_comb begin
      hit_if  = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
      hit_ex  = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
      Br_pred = hit_if && cnt_q[idx_if][1];
      PC_pred = Br_pred ? target_q[idx_if] : PC_IF + 32'd4;
   end

   // EX resolution: direction mismatch only; target is not compared.
   always_comb begin
      mispredict = update_en && (br_taken_EX != Br_pred_EX);
      PC_correct = br_taken_EX ? br_target_EX : PC_EX + 32'd4;
   end

   // Table training: hits adjust the counter, taken misses allocate.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (update_en) begin
         if (hit_ex) begin
            if (br_taken_EX) begin
               if (cnt_q[idx_ex] != 2'b11) begin
                  cnt_d[idx_ex] = cnt_q[idx_ex] + 2'd1;
               end
               target_d[idx_ex] = br_target_EX;
            end else if (cnt_q[idx_ex] != 2'b00) begin
               cnt_d[idx_ex] = cnt_q[idx_ex] - 2'd1;
            end
         end else if (br_taken_EX) begin
            valid_d[idx_ex]  = 1'b1;
            tag_d[idx_ex]    = tag_ex;
            target_d[idx_ex] = br_target_EX;
            cnt_d[idx_ex]    = 2'b10;
         end
      end
   end

   // Saturating statistics counters.
   always_comb begin
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (update_en && (branch_cnt_q != 32'hFFFF_FFFF)) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
         mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
   end

   // State registers; reset clears the whole table and wins over training.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= 2'b01;
         end
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         cnt_q         <= cnt_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_cnt  = branch_cnt_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: stimulus rows carry the expected
// prediction, which is queued when driven and compared before the edge.
module tb_branch_predictor_bht;

   logic        clk;
   logic        rst;
   logic [31:0] PC_IF;
   logic        Br_pred;
   logic [31:0] PC_pred;
   logic        update_en;
   logic [31:0] PC_EX;
   logic        Br_pred_EX;
   logic        br_taken_EX;
   logic [31:0] br_target_EX;
   logic        mispredict;
   logic [31:0] PC_correct;
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   branch_predictor_bht dut (
      .clk          (clk),
      .rst          (rst),
      .PC_IF        (PC_IF),
      .Br_pred      (Br_pred),
      .PC_pred      (PC_pred),
      .update_en    (update_en),
      .PC_EX        (PC_EX),
      .Br_pred_EX   (Br_pred_EX),
      .br_taken_EX  (br_taken_EX),
      .br_target_EX (br_target_EX),
      .mispredict   (mispredict),
      .PC_correct   (PC_correct),
      .branch_cnt   (branch_cnt),
      .mispred_cnt  (mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc_if;
      logic        upd;
      logic [31:0] pc_ex;
      logic        pred_ex;
      logic        taken;
      logic [31:0] tgt;
      logic        exp_pred;
      logic [31:0] exp_pc;
   } row_t;

   typedef struct {
      logic        br_pred;
      logic [31:0] pc_pred;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_br   = 0;
   logic [31:0] exp_mis  = 0;

   // Drive one cycle of stimulus at the falling edge, first folding the
   // previous cycle's update into the expected statistics.
   task automatic step(input row_t r);
      @(negedge clk);
      if (rst) begin
         exp_br  = 0;
         exp_mis = 0;
      end else if (update_en) begin
         if (exp_br != 32'hFFFF_FFFF) exp_br++;
         if ((br_taken_EX != Br_pred_EX) && (exp_mis != 32'hFFFF_FFFF)) exp_mis++;
      end
      rst          = 1'b0;
      PC_IF        = r.pc_if;
      update_en    = r.upd;
      PC_EX        = r.pc_ex;
      Br_pred_EX   = r.pred_ex;
      br_taken_EX  = r.taken;
      br_target_EX = r.tgt;
      sb_q.push_back('{r.exp_pred, r.exp_pc});
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      rst = 1'b1; update_en = 1'b0; PC_IF = 32'h40;
      step('{32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44});
      e = sb_q.pop_front();
      checks++;
      if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
         failures++;
         $display("FAIL reset_pred got %0b/%h expected %0b/%h", Br_pred, PC_pred, e.br_pred, e.pc_pred);
      end
      checks++;
      if (mispredict !== 1'b0 || branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_state got mis=%0b br=%0d mp=%0d expected 0/0/0", mispredict, branch_cnt, mispred_cnt);
      end
   endtask

   task automatic test_allocation();
      exp_t e;
      step('{32'h200, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h204});
      e = sb_q.pop_front();
      checks++;
      if (mispredict !== 1'b1 || PC_correct !== 32'h100) begin
         failures++;
         $display("FAIL alloc_resolve got mis=%0b pc=%h expected 1/00000100", mispredict, PC_correct);
      end
      checks++;
      if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
         failures++;
         $display("FAIL alloc_other got %0b/%h expected %0b/%h", Br_pred, PC_pred, e.br_pred, e.pc_pred);
      end
      step('{32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100});
      e = sb_q.pop_front();
      checks++;
      if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
         failures++;
         $display("FAIL alloc_pred got %0b/%h expected %0b/%h", Br_pred, PC_pred, e.br_pred, e.pc_pred);
      end
      checks++;
      if (branch_cnt !== 32'd1 || mispred_cnt !== 32'd1) begin
         failures++;
         $display("FAIL alloc_counts got %0d/%0d expected 1/1", branch_cnt, mispred_cnt);
      end
   endtask

   task automatic test_hysteresis();
      row_t rows[$];
      exp_t e;
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100}); // 10 -> 01
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44});  // 01 -> 10
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h180, 1'b1, 32'h100}); // 10 -> 11, new target
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,   1'b1, 32'h180}); // 11 -> 10
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h180}); // 10 -> 11
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100}); // saturated
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100});
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100});
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100}); // 11 -> 10
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100}); // 10 -> 01
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44});  // 01 -> 00
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44});  // saturated at 00
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44});  // 00 -> 01
      rows.push_back('{32'h40, 1'b1, 32'h40, 1'b0, 1'b1, 32'h100, 1'b0, 32'h44});  // 01 -> 10
      rows.push_back('{32'h40, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   1'b1, 32'h100});
      foreach (rows[i]) begin
         step(rows[i]);
         e = sb_q.pop_front();
         checks++;
         if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
            failures++;
            $display("FAIL hyst[%0d] got %0b/%h expected %0b/%h", i, Br_pred, PC_pred, e.br_pred, e.pc_pred);
         end
      end
      checks++;
      if (branch_cnt !== exp_br || mispred_cnt !== exp_mis) begin
         failures++;
         $display("FAIL hyst_counts got %0d/%0d expected %0d/%0d", branch_cnt, mispred_cnt, exp_br, exp_mis);
      end
   endtask

   task automatic test_aliasing();
      row_t rows[$];
      exp_t e;
      rows.push_back('{32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144});
      rows.push_back('{32'h40,  1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h44});
      rows.push_back('{32'h140, 1'b1, 32'h240, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300});
      rows.push_back('{32'h140, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h300});
      rows.push_back('{32'h240, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h244});
      foreach (rows[i]) begin
         step(rows[i]);
         e = sb_q.pop_front();
         checks++;
         if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
            failures++;
            $display("FAIL alias[%0d] got %0b/%h expected %0b/%h", i, Br_pred, PC_pred, e.br_pred, e.pc_pred);
         end
         if (i == 2) begin
            checks++;
            if (mispredict !== 1'b0 || PC_correct !== 32'h244) begin
               failures++;
               $display("FAIL alias_nt_resolve got mis=%0b pc=%h expected 0/00000244", mispredict, PC_correct);
            end
         end
      end
   endtask

   task automatic test_collision();
      row_t rows[$];
      exp_t e;
      rows.push_back('{32'h80,       1'b1, 32'h80,       1'b0, 1'b1, 32'h400, 1'b0, 32'h84});
      rows.push_back('{32'h80,       1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 32'h400});
      rows.push_back('{32'h82,       1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 32'h400});
      rows.push_back('{32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0});
      foreach (rows[i]) begin
         step(rows[i]);
         e = sb_q.pop_front();
         checks++;
         if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
            failures++;
            $display("FAIL coll[%0d] got %0b/%h expected %0b/%h", i, Br_pred, PC_pred, e.br_pred, e.pc_pred);
         end
      end
      checks++;
      if (mispredict !== 1'b0 || PC_correct !== 32'h0) begin
         failures++;
         $display("FAIL wrap_resolve got mis=%0b pc=%h expected 0/00000000", mispredict, PC_correct);
      end
      step('{32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44});
      e = sb_q.pop_front();
      checks++;
      if (branch_cnt !== exp_br || mispred_cnt !== exp_mis) begin
         failures++;
         $display("FAIL coll_counts got %0d/%0d expected %0d/%0d", branch_cnt, mispred_cnt, exp_br, exp_mis);
      end
   endtask

   task automatic test_reset_mid_training();
      row_t rows[$];
      exp_t e;
      @(negedge clk);
      if (update_en) begin
         exp_br++;
         if (br_taken_EX != Br_pred_EX) exp_mis++;
      end
      rst = 1'b1; update_en = 1'b1; PC_EX = 32'h500; Br_pred_EX = 1'b0;
      br_taken_EX = 1'b1; br_target_EX = 32'h600; PC_IF = 32'h500;
      rows.push_back('{32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h504});
      rows.push_back('{32'h80,  1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h84});
      rows.push_back('{32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h144});
      foreach (rows[i]) begin
         step(rows[i]);
         e = sb_q.pop_front();
         checks++;
         if (Br_pred !== e.br_pred || PC_pred !== e.pc_pred) begin
            failures++;
            $display("FAIL rstmid[%0d] got %0b/%h expected %0b/%h", i, Br_pred, PC_pred, e.br_pred, e.pc_pred);
         end
      end
      checks++;
      if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
         failures++;
         $display("FAIL rstmid_counts got %0d/%0d expected 0/0", branch_cnt, mispred_cnt);
      end
   endtask

   initial begin
      rst          = 1'b1;
      PC_IF        = 32'h0;
      update_en    = 1'b0;
      PC_EX        = 32'h0;
      Br_pred_EX   = 1'b0;
      br_taken_EX  = 1'b0;
      br_target_EX = 32'h0;
      test_reset();
      test_allocation();
      test_hysteresis();
      test_aliasing();
      test_collision();
      test_reset_mid_training();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
